// File: rtl/ud_counter_if.sv
// Bus bundle for the up/down counter: control, load/reset data and outputs.
interface ud_counter_if #(
    parameter int SIZE = 8
);
    logic            cnt_en;
    logic            ud;
    logic            nld;
    logic            rci;
    logic [SIZE-1:0] d;
    logic [SIZE-1:0] resd;
    logic [SIZE-1:0] q;
    logic            rco;

    // Controller side: drives the counter controls and observes q and rco.
    modport master (
        output cnt_en, ud, nld, rci, d, resd,
        input  q, rco
    );

    // Counter side.
    modport slave (
        input  cnt_en, ud, nld, rci, d, resd,
        output q, rco
    );
endinterface

// File: rtl/ud_counter.sv
// Parameterised up/down counter with parallel load, carry-in enable and a
// combinational carry-out for cascading.
module ud_counter #(
    parameter int SIZE = 8
) (
    input  logic clk,
    input  logic nReset,
    input  logic rst,
    ud_counter_if.slave bus
);

    logic [SIZE-1:0] qi;
    logic [SIZE-1:0] q_cur;
    logic [SIZE-1:0] q_nxt;
    logic            in_reset;

    // Terminal count for the given direction: all-ones counting up, zero down.
    function automatic logic at_terminal(input logic [SIZE-1:0] v, input logic up);
        return up ? (&v) : ~(|v);
    endfunction

    // Asynchronous reset flag: while set, q shows resd directly, so q tracks
    // resd for as long as nReset is low and still equals resd after release
    // until the first clock edge takes over.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            in_reset <= 1'b1;
        end else begin
            in_reset <= 1'b0;
        end
    end

    assign q_cur = in_reset ? bus.resd : qi;

    // Next-state priority: sync reset, enable, load, then counting on rci.
    always_comb begin
        q_nxt = q_cur;
        if (rst) begin
            q_nxt = bus.resd;
        end else if (bus.cnt_en) begin
            if (!bus.nld) begin
                q_nxt = bus.d;
            end else if (bus.rci) begin
                q_nxt = bus.ud ? q_cur + 1'b1 : q_cur - 1'b1;
            end
        end
    end

    // Count register; its value is masked by in_reset while reset is active.
    always_ff @(posedge clk) begin
        qi <= q_nxt;
    end

    assign bus.q   = q_cur;
    assign bus.rco = bus.rci & at_terminal(q_cur, bus.ud);

endmodule

// File: tb/tb_ud_counter.sv
// Self-checking bench for ud_counter: vector table, hand sequences for the
// asynchronous and combinational corners, random run against a model, and a
// two-stage 4-bit cascade.
module tb_ud_counter;

    logic clk;
    logic nReset;
    logic rst;
    logic rst_c;
    int   checks;
    int   errors;

    ud_counter_if #(.SIZE(8)) m_if ();
    ud_counter_if #(.SIZE(4)) lo_if ();
    ud_counter_if #(.SIZE(4)) hi_if ();

    ud_counter #(.SIZE(8)) dut (.clk(clk), .nReset(nReset), .rst(rst), .bus(m_if));
    ud_counter #(.SIZE(4)) u_lo (.clk(clk), .nReset(nReset), .rst(rst_c), .bus(lo_if));
    ud_counter #(.SIZE(4)) u_hi (.clk(clk), .nReset(nReset), .rst(rst_c), .bus(hi_if));

    assign hi_if.rci = lo_if.rco;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cnt_en;
        logic       ud;
        logic       nld;
        logic       rci;
        logic [7:0] d;
        logic [7:0] resd;
        logic [7:0] exp_q;
        logic       exp_rco;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic en, input logic u, input logic l,
                       input logic c, input logic [7:0] dv, input logic [7:0] rv,
                       input logic [7:0] eq, input logic er);
        vec_t v;
        v.rst = r; v.cnt_en = en; v.ud = u; v.nld = l; v.rci = c;
        v.d = dv; v.resd = rv; v.exp_q = eq; v.exp_rco = er;
        vecs.push_back(v);
    endtask

    int          mq;
    logic [7:0]  rd;
    logic [7:0]  rr;
    logic        r_rst, r_en, r_ud, r_nld, r_rci;
    logic        exp_rco;

    initial begin
        checks = 0;
        errors = 0;
        nReset = 1'b1;
        rst    = 1'b0;
        rst_c  = 1'b1;
        m_if.cnt_en = 1'b0; m_if.ud = 1'b0; m_if.nld = 1'b1; m_if.rci = 1'b0;
        m_if.d = 8'h00; m_if.resd = 8'h5A;
        lo_if.cnt_en = 1'b1; lo_if.ud = 1'b1; lo_if.nld = 1'b1; lo_if.rci = 1'b1;
        lo_if.d = 4'h0; lo_if.resd = 4'h0;
        hi_if.cnt_en = 1'b1; hi_if.ud = 1'b1; hi_if.nld = 1'b1;
        hi_if.d = 4'h0; hi_if.resd = 4'h0;

        // Asynchronous reset, away from any clock edge.
        @(posedge clk);
        #2;
        nReset = 1'b0;
        #1;
        check("async_reset_q", m_if.q, 8'h5A);
        m_if.resd = 8'h33;
        #1;
        check("reset_follows_resd", m_if.q, 8'h33);
        m_if.resd = 8'h00; m_if.rci = 1'b1;
        #1;
        check("reset_rco_terminal", m_if.rco, 1'b1);
        m_if.resd = 8'h5A; m_if.rci = 1'b0;
        #1;
        nReset = 1'b1;
        #1;
        check("after_release_q", m_if.q, 8'h5A);
        step();
        check("hold_after_reset", m_if.q, 8'h5A);

        // Vector table, applied in sequence from q=5A.
        add(0,1,0,0,1,8'h03,8'h5A,8'h03,0);
        add(0,1,0,1,1,8'h03,8'h5A,8'h02,0);
        add(0,1,0,1,1,8'h03,8'h5A,8'h01,0);
        add(0,1,0,1,1,8'h03,8'h5A,8'h00,1);
        add(0,1,0,1,1,8'h03,8'h5A,8'hFF,0);
        add(0,1,1,0,1,8'hFE,8'h5A,8'hFE,0);
        add(0,1,1,1,1,8'hFE,8'h5A,8'hFF,1);
        add(0,1,1,1,1,8'hFE,8'h5A,8'h00,0);
        add(0,1,1,1,1,8'hFE,8'h5A,8'h01,0);
        add(0,1,1,0,1,8'd10,8'h5A,8'd10,0);
        add(0,0,1,1,1,8'd10,8'h5A,8'd10,0);
        add(0,0,1,0,1,8'd77,8'h5A,8'd10,0);
        add(0,0,0,1,1,8'd10,8'h5A,8'd10,0);
        add(0,1,1,1,0,8'd10,8'h5A,8'd10,0);
        add(0,1,1,0,1,8'd7,8'h5A,8'd7,0);
        add(1,0,1,0,0,8'd9,8'h11,8'h11,0);
        add(1,1,0,1,1,8'd9,8'hFF,8'hFF,0);
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            m_if.cnt_en = vecs[i].cnt_en; m_if.ud = vecs[i].ud;
            m_if.nld = vecs[i].nld; m_if.rci = vecs[i].rci;
            m_if.d = vecs[i].d; m_if.resd = vecs[i].resd;
            step();
            check($sformatf("vec%0d_q", i), m_if.q, vecs[i].exp_q);
            check($sformatf("vec%0d_rco", i), m_if.rco, vecs[i].exp_rco);
        end
        rst = 1'b0;

        // Combinational rco: load zero, then toggle rci and ud without edges.
        m_if.cnt_en = 1'b1; m_if.nld = 1'b0; m_if.d = 8'h00; m_if.rci = 1'b0; m_if.ud = 1'b0;
        step();
        m_if.nld = 1'b1;
        #1;
        check("rco_rci_low", m_if.rco, 1'b0);
        m_if.rci = 1'b1;
        #1;
        check("rco_rci_rise", m_if.rco, 1'b1);
        m_if.ud = 1'b1;
        #1;
        check("rco_ud_flip", m_if.rco, 1'b0);
        check("rco_no_edge_q", m_if.q, 8'h00);

        // Random run against an arithmetic model.
        mq = 0;
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 15) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_ud  = $urandom_range(0, 1);
            r_nld = ($urandom_range(0, 7) != 0);
            r_rci = ($urandom_range(0, 4) != 0);
            rd    = 8'($urandom);
            rr    = 8'($urandom);
            rst = r_rst; m_if.cnt_en = r_en; m_if.ud = r_ud; m_if.nld = r_nld;
            m_if.rci = r_rci; m_if.d = rd; m_if.resd = rr;
            if (r_rst)            mq = rr;
            else if (!r_en)       mq = mq;
            else if (!r_nld)      mq = rd;
            else if (r_rci)       mq = r_ud ? (mq + 1) % 256 : (mq + 255) % 256;
            step();
            exp_rco = r_rci && (r_ud ? (mq == 255) : (mq == 0));
            check("rand_q", m_if.q, mq[7:0]);
            check("rand_rco", m_if.rco, exp_rco);
        end
        rst = 1'b0;

        // Cascade of two 4-bit counters: combined value counts 0..255 and wraps.
        check("cascade_start", {hi_if.q, lo_if.q}, 8'h00);
        rst_c = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            step();
            check("cascade_value", {hi_if.q, lo_if.q}, k % 256);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ud_counter.md
Name: ud_counter

Overview:
- Parameterised synchronous up/down counter with parallel load, ripple-carry-in enable (rci) and combinational ripple-carry-out (rco).
- Generic building block for timing generators. Example use: a run-once down-counter loads d on a start pulse, counts to zero, and uses rco as its "done" strobe (D+1 cycles from load to done).
- Counters can be cascaded by chaining one counter's rco into the next counter's rci.

Parameters:
- SIZE, 8, counter width in bits (SIZE >= 1).

Ports:
- clk  input  1  master clock; all state changes on the rising edge.
- nReset  input  1  asynchronous reset, active low.
- rst  input  1  synchronous reset, active high.
- cnt_en  input  1  global clock enable; gates load and count, but not rst.
- ud  input  1  direction: 1 = count up, 0 = count down.
- nld  input  1  load, active low; q <= d when low and cnt_en is high.
- d  input  SIZE  parallel load value.
- q  output  SIZE  current counter value (registered).
- resd  input  SIZE  reset value, loaded by either reset.
- rci  input  1  ripple carry in; counting advances only when high.
- rco  output  1  ripple carry out (terminal count reached while rci is high).

Behaviour:
- Single SIZE-bit register Qi; q = Qi.
- Priority at each rising clk edge, highest first:
  1. nReset low: Qi <= resd, asynchronously and immediately, independent of clk.
  2. rst high: Qi <= resd, regardless of cnt_en.
  3. cnt_en low: Qi holds.
  4. nld low: Qi <= d. Load wins over counting; rci and ud are ignored.
  5. rci high: Qi <= Qi+1 if ud=1, else Qi <= Qi-1. Arithmetic is modulo 2^SIZE.
  6. Otherwise Qi holds.
- resd is sampled while nReset is asserted. If resd changes during nReset low, q follows it. Deasserting nReset leaves q = resd.
- Wrap-around:
  - Up: all-ones -> 0.
  - Down: 0 -> all-ones.
  - No saturation; wrap happens even while rco is high.
- rco is purely combinational, with no clock latency:
  - Up: rco = rci AND (q == all-ones).
  - Down: rco = rci AND (q == 0).
  - rco is not gated by cnt_en, nld or rst. It reflects the current q, ud and rci only.
- During reset, q = resd, so rco = rci AND terminal(resd).
- Load of the terminal value with rci high: rco asserts in the cycle after the load edge (once q updates).
- ud may change at any cycle. rco re-evaluates combinationally against the new direction's terminal value.
- No X-propagation requirement beyond the inputs. All outputs are defined after the first reset.

Test Plan:
1. Reset: SIZE=8, resd=8'h5A, pulse nReset low -> q=8'h5A asynchronously, before any clk edge. Raise rst for 1 cycle with cnt_en=0 and resd=8'h11 -> q=8'h11 after the edge.
2. Load and count down: cnt_en=1, nld=0, d=3 for 1 cycle, then nld=1, rci=1, ud=0 -> q = 3,2,1,0 on successive edges. rco=1 exactly while q=0 (4th cycle after load, i.e. D+1 cycles). Next edge gives q=8'hFF and rco=0.
3. Count up with wrap: load d=8'hFE, ud=1, rci=1 -> q = FE, FF, 00, 01. rco=1 only while q=FF.
4. Enables: with q=10 and rci=1, drop cnt_en for 3 cycles -> q holds at 10. With cnt_en=1 and rci=0 -> q holds. Assert nld=0 (d=7) together with rci=1 -> q=7, so load wins.
5. rco combinational: hold q=0 with rci=0 -> rco=0. Raise rci with no clock edge -> rco=1 the same cycle. Switch ud to 1 -> rco=0 immediately.
6. Cascade: SIZE=4, two instances, low rco driving high rci, both counting up from 0 -> the high nibble increments once per 16 cycles. The combined 8-bit value counts 0..255 and wraps to 0.
